alu8_seq_ctrl: RTL and testbench

- Instruction-side sequencer that drives the 8-bit ALU datapath, the other end of the ALU's control/flag interface.
- Accepts one 14-bit byte-oriented instruction per handshake and decodes it into ALU select controls.
- Fetches the file operand, presents ALU operands, and captures the result and C/DC/Z.
- Writes the result to W or the file register and maintains the STATUS flag bits.

---
 rtl/alu8_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu8_seq_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_seq_ctrl.sv
`timescale 1ns/1ps
// Instruction sequencer for the 8-bit ALU. It fetches F, drives the ALU selects, captures the result and writes back to W or F.
// Legal ops take cycles 0-4 with done in cycle 4. Illegal ops and NOP finish in cycle 1. instr_ready is high only in IDLE, so there is no queueing.
module alu8_seq_ctrl #(
  parameter int         ADDR_W = 7,
  parameter logic [7:0] W_RST  = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [13:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] f_addr,
  output logic              f_rd_en,
  input  logic [7:0]        f_rd_data,
  output logic              f_wr_en,
  output logic [7:0]        f_wr_data,
  output logic [7:0]        op_a1,
  output logic [7:0]        op_a,
  output logic [7:0]        op_b,
  output logic              clr,
  output logic              swap_n_mov,
  output logic              rlf_n_rrf,
  output logic              sub,
  output logic [1:0]        op_mux_l,
  output logic [1:0]        op_mux_a,
  output logic [1:0]        out_mux,
  output logic              c_in,
  input  logic [7:0]        alu_result,
  input  logic              c_new,
  input  logic              dc_new,
  input  logic              z_new,
  output logic [7:0]        w_q,
  output logic              status_c,
  output logic              status_dc,
  output logic              status_z,
  output logic              done,
  output logic              skip,
  output logic              illegal
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_OPL  = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_DN   = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_f, r_res, r_w;
  logic              r_c, r_dc, r_z;
  logic              r_sc, r_sdc, r_sz;
  logic              r_clr, r_swap, r_rlf, r_sub, r_sel_w, r_wr_f, r_skip_op, r_ill;
  logic [1:0]        r_op_mux_l, r_op_mux_a, r_out_mux;
  logic [2:0]        r_mask;

  logic       w_illegal, w_nop;
  logic       w_clr, w_swap, w_rlf, w_sub, w_sel_w, w_wr_f, w_skip_op;
  logic [1:0] w_op_mux_l, w_op_mux_a, w_out_mux;
  logic [2:0] w_mask;

  assign w_illegal = (instr[13:12] != 2'b00);
  assign w_nop     = (instr[11:8] == 4'h0) && !instr[7];

  // Flag mask bits are {C, DC, Z}. Illegal ops and NOP leave every control at 0.
  always_comb begin
    w_clr = 1'b0; w_swap = 1'b0; w_rlf = 1'b0; w_sub = 1'b0;
    w_sel_w = 1'b0; w_skip_op = 1'b0; w_mask = 3'b000;
    w_op_mux_l = 2'd0; w_op_mux_a = 2'd0; w_out_mux = 2'd0;
    w_wr_f = instr[7] || (instr[11:8] == 4'h0);
    if (!(w_illegal || w_nop)) begin
      case (instr[11:8])
        4'h0: w_sel_w = 1'b1;
        4'h1: begin w_clr = 1'b1; w_mask = 3'b001; end
        4'h2: begin w_out_mux = 2'd3; w_op_mux_a = 2'd1; w_sub = 1'b1; w_mask = 3'b111; end
        4'h3: begin w_out_mux = 2'd3; w_op_mux_a = 2'd3; w_mask = 3'b001; end
        4'h4: begin w_out_mux = 2'd2; w_op_mux_l = 2'd0; w_mask = 3'b001; end
        4'h5: begin w_out_mux = 2'd2; w_op_mux_l = 2'd1; w_mask = 3'b001; end
        4'h6: begin w_out_mux = 2'd2; w_op_mux_l = 2'd2; w_mask = 3'b001; end
        4'h7: begin w_out_mux = 2'd3; w_op_mux_a = 2'd0; w_mask = 3'b111; end
        4'h8: w_mask = 3'b001;
        4'h9: begin w_out_mux = 2'd2; w_op_mux_l = 2'd3; w_mask = 3'b001; end
        4'hA: begin w_out_mux = 2'd3; w_op_mux_a = 2'd2; w_mask = 3'b001; end
        4'hB: begin w_out_mux = 2'd3; w_op_mux_a = 2'd3; w_skip_op = 1'b1; end
        4'hC: begin w_out_mux = 2'd1; w_mask = 3'b100; end
        4'hD: begin w_out_mux = 2'd1; w_rlf = 1'b1; w_mask = 3'b100; end
        4'hE: w_swap = 1'b1;
        default: begin w_out_mux = 2'd3; w_op_mux_a = 2'd2; w_skip_op = 1'b1; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;   r_addr <= '0;
      r_f <= 8'h00;        r_res <= 8'h00;    r_w <= W_RST;
      r_c <= 1'b0;         r_dc <= 1'b0;      r_z <= 1'b0;
      r_sc <= 1'b0;        r_sdc <= 1'b0;     r_sz <= 1'b0;
      r_clr <= 1'b0;       r_swap <= 1'b0;    r_rlf <= 1'b0;      r_sub <= 1'b0;
      r_sel_w <= 1'b0;     r_wr_f <= 1'b0;    r_skip_op <= 1'b0;  r_ill <= 1'b0;
      r_op_mux_l <= 2'd0;  r_op_mux_a <= 2'd0; r_out_mux <= 2'd0; r_mask <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: if (instr_valid) begin
          r_addr <= instr[ADDR_W-1:0];
          r_clr <= w_clr;           r_swap <= w_swap;         r_rlf <= w_rlf;
          r_sub <= w_sub;           r_sel_w <= w_sel_w;       r_wr_f <= w_wr_f;
          r_skip_op <= w_skip_op;   r_mask <= w_mask;         r_ill <= w_illegal;
          r_op_mux_l <= w_op_mux_l; r_op_mux_a <= w_op_mux_a; r_out_mux <= w_out_mux;
          r_state <= (w_illegal || w_nop) ? S_DN : S_RD;
        end
        S_RD:  r_state <= S_OPL;
        S_OPL: begin r_f <= f_rd_data; r_state <= S_EX; end
        S_EX: begin
          r_res <= alu_result; r_c <= c_new; r_dc <= dc_new; r_z <= z_new;
          r_state <= S_WB;
        end
        S_WB: begin
          if (!r_wr_f)   r_w   <= r_res;
          if (r_mask[2]) r_sc  <= r_c;
          if (r_mask[1]) r_sdc <= r_dc;
          if (r_mask[0]) r_sz  <= r_z;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign f_addr      = r_addr;
  assign f_rd_en     = (r_state == S_RD);
  assign f_wr_en     = (r_state == S_WB) && r_wr_f;
  assign f_wr_data   = r_res;
  assign op_a1       = r_sel_w ? r_w : r_f;
  assign op_a        = r_f;
  assign op_b        = r_w;
  assign clr         = r_clr;
  assign swap_n_mov  = r_swap;
  assign rlf_n_rrf   = r_rlf;
  assign sub         = r_sub;
  assign op_mux_l    = r_op_mux_l;
  assign op_mux_a    = r_op_mux_a;
  assign out_mux     = r_out_mux;
  assign c_in        = r_sc;
  assign w_q         = r_w;
  assign status_c    = r_sc;
  assign status_dc   = r_sdc;
  assign status_z    = r_sz;
  assign done        = (r_state == S_WB) || (r_state == S_DN);
  assign illegal     = (r_state == S_DN) && r_ill;
  assign skip        = (r_state == S_WB) && r_skip_op && (r_res == 8'h00);

endmodule

// File: tb/tb_alu8_seq_ctrl.sv
`timescale 1ns/1ps
// Bench for alu8_seq_ctrl. A behavioural ALU and file memory sit around the DUT.
// Directed vectors, randomized instructions against an arithmetic reference model, and reset and back-to-back sequences.
module tb_alu8_seq_ctrl;

  logic clk = 1'b0, rst_n = 1'b0;
  logic instr_valid = 1'b0;
  logic [13:0] instr = 14'h0;
  logic instr_ready, f_rd_en, f_wr_en;
  logic [6:0] f_addr;
  logic [7:0] f_rd_data = 8'h00, f_wr_data, op_a1, op_a, op_b, alu_result, w_q;
  logic clr, swap_n_mov, rlf_n_rrf, sub, c_in, c_new, dc_new, z_new;
  logic [1:0] op_mux_l, op_mux_a, out_mux;
  logic status_c, status_dc, status_z, done, skip, illegal;

  alu8_seq_ctrl #(.ADDR_W(7), .W_RST(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .f_addr(f_addr), .f_rd_en(f_rd_en), .f_rd_data(f_rd_data), .f_wr_en(f_wr_en), .f_wr_data(f_wr_data),
    .op_a1(op_a1), .op_a(op_a), .op_b(op_b), .clr(clr), .swap_n_mov(swap_n_mov), .rlf_n_rrf(rlf_n_rrf),
    .sub(sub), .op_mux_l(op_mux_l), .op_mux_a(op_mux_a), .out_mux(out_mux), .c_in(c_in),
    .alu_result(alu_result), .c_new(c_new), .dc_new(dc_new), .z_new(z_new), .w_q(w_q),
    .status_c(status_c), .status_dc(status_dc), .status_z(status_z), .done(done), .skip(skip), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [7:0] fmem [128];
  always @(posedge clk) if (f_rd_en) f_rd_data <= fmem[f_addr];

  logic [8:0] alu_s;
  logic [4:0] alu_n;
  always_comb begin
    alu_s = '0; alu_n = '0; alu_result = 8'h00; c_new = 1'b0; dc_new = 1'b0; z_new = 1'b0;
    case (out_mux)
      2'd0: alu_result = clr ? 8'h00 : (swap_n_mov ? {op_a1[3:0], op_a1[7:4]} : op_a1);
      2'd1: if (rlf_n_rrf) {c_new, alu_result} = {op_a1, c_in};
            else           {alu_result, c_new} = {c_in, op_a1};
      2'd2: case (op_mux_l)
              2'd0: alu_result = op_a | op_b;
              2'd1: alu_result = op_a & op_b;
              2'd2: alu_result = op_a ^ op_b;
              default: alu_result = ~op_a;
            endcase
      default: begin
        case (op_mux_a)
          2'd0: begin alu_s = {1'b0, op_a} + {1'b0, op_b}; alu_n = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]}; end
          2'd1: if (sub) begin
                  alu_s = {1'b0, op_a} + {1'b0, ~op_b} + 9'd1;
                  alu_n = {1'b0, op_a[3:0]} + {1'b0, ~op_b[3:0]} + 5'd1;
                end
          2'd2: alu_s = {1'b0, op_a} + 9'd1;
          default: alu_s = {1'b0, op_a} + 9'h0FF;
        endcase
        alu_result = alu_s[7:0]; c_new = alu_s[8]; dc_new = alu_n[4];
      end
    endcase
    z_new = (alu_result == 8'h00);
  end

  int n_tests = 0, n_fail = 0;
  logic [7:0] mW = 8'h00;
  logic mC = 1'b0, mDC = 1'b0, mZ = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: instruction semantics in plain integer arithmetic; updates mW/mC/mDC/mZ.
  task automatic ref_exec(input logic [13:0] ins, input logic [7:0] fv, output logic sh, output logic il,
                          output logic wr, output logic [7:0] wd, output logic sk, output logic cin0);
    int op, a, w, r;
    logic d, uz;
    op = int'(ins[11:8]); d = ins[7]; a = int'(fv); w = int'(mW); r = 0; uz = 1'b0;
    sk = 1'b0; wr = 1'b0; wd = 8'h00; cin0 = mC;
    il = (ins[13:12] != 2'b00);
    sh = il || (op == 0 && !d);
    if (sh) return;
    case (op)
      0:  r = w;
      1:  begin r = 0; uz = 1'b1; end
      2:  begin r = (a - w) & 255; mC = (a >= w); mDC = ((a & 15) >= (w & 15)); uz = 1'b1; end
      3:  begin r = (a + 255) & 255; uz = 1'b1; end
      4:  begin r = a | w; uz = 1'b1; end
      5:  begin r = a & w; uz = 1'b1; end
      6:  begin r = a ^ w; uz = 1'b1; end
      7:  begin r = (a + w) & 255; mC = ((a + w) > 255); mDC = (((a & 15) + (w & 15)) > 15); uz = 1'b1; end
      8:  begin r = a; uz = 1'b1; end
      9:  begin r = (~a) & 255; uz = 1'b1; end
      10: begin r = (a + 1) & 255; uz = 1'b1; end
      11: begin r = (a + 255) & 255; sk = (r == 0); end
      12: begin r = (int'(mC) * 128) + (a / 2); mC = ((a % 2) == 1); end
      13: begin r = ((a * 2) + int'(mC)) & 255; mC = (a >= 128); end
      14: r = ((a % 16) * 16) + (a / 16);
      default: begin r = (a + 1) & 255; sk = (r == 0); end
    endcase
    if (uz) mZ = (r == 0);
    wd = 8'(r);
    wr = d || (op == 0);
    if (!wr) mW = 8'(r);
  endtask

  task automatic apply_chk(input string tg, input logic [13:0] ins, input logic [7:0] fv, input logic sh,
                           input logic il, input logic wr, input logic [7:0] wd, input logic sk,
                           input logic [7:0] ew, input logic ec, input logic edc, input logic ez, input logic ecin);
    int dcyc, dcnt, rcyc, rdc, wrc, t;
    logic [7:0] wdat;
    logic [6:0] wad;
    logic il_s, sk_s, cin_s;
    dcyc = -1; dcnt = 0; rcyc = -1; rdc = 0; wrc = 0; t = 0;
    wdat = 8'h00; wad = 7'h00; il_s = 1'b0; sk_s = 1'b0; cin_s = 1'b0;
    fmem[ins[6:0]] = fv;
    @(negedge clk); instr_valid = 1'b1; instr = ins;
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin instr_valid = 1'b0; instr = 14'($urandom); end
      if (done) begin dcnt++; if (dcyc < 0) dcyc = k; end
      if (f_rd_en) rdc++;
      if (f_wr_en) begin wrc++; wdat = f_wr_data; wad = f_addr; end
      il_s |= illegal; sk_s |= skip;
      if (k == 3) cin_s = c_in;
      if (instr_ready) begin rcyc = k; break; end
    end
    chk({tg, " done_cycle"}, dcyc, sh ? 1 : 4);
    chk({tg, " done_count"}, dcnt, 1);
    chk({tg, " ready_cycle"}, rcyc, sh ? 2 : 5);
    chk({tg, " rd_count"}, rdc, sh ? 0 : 1);
    chk({tg, " wr_count"}, wrc, wr ? 1 : 0);
    if (wr) begin
      chk({tg, " wr_data"}, int'(wdat), int'(wd));
      chk({tg, " wr_addr"}, int'(wad), int'(ins[6:0]));
    end
    chk({tg, " illegal"}, int'(il_s), int'(il));
    chk({tg, " skip"}, int'(sk_s), int'(sk));
    if (!sh) chk({tg, " c_in_ex"}, int'(cin_s), int'(ecin));
    chk({tg, " w_q"}, int'(w_q), int'(ew));
    chk({tg, " status"}, int'({status_c, status_dc, status_z}), int'({ec, edc, ez}));
  endtask

  typedef struct {
    logic [13:0] ins;  logic [7:0] fv;  logic sh, il, wr;  logic [7:0] wd;
    logic sk;  logic [7:0] w;  logic c, dc, z;
  } vec_t;

  function automatic vec_t mk(logic [13:0] ins, logic [7:0] fv, logic sh, logic il, logic wr, logic [7:0] wd,
                              logic sk, logic [7:0] w, logic c, logic dc, logic z);
    vec_t v;
    v.ins = ins; v.fv = fv; v.sh = sh; v.il = il; v.wr = wr; v.wd = wd;
    v.sk = sk; v.w = w; v.c = c; v.dc = dc; v.z = z;
    return v;
  endfunction

  vec_t tbl [14];
  logic prev_c;
  logic [13:0] r_ins;
  logic [7:0] r_fv, r_wd;
  logic r_sh, r_il, r_wr, r_sk, r_cin, rdy5;
  int t, lows, wk, rk, wrc;
  logic [7:0] wd;
  logic [6:0] wa;

  initial begin
    //             ins       F      sh il wr data sk W      C  DC Z
    tbl[0]  = mk(14'h0810, 8'h0F, 0, 0, 0, 8'h00, 0, 8'h0F, 0, 0, 0); // MOVF 0x10,W
    tbl[1]  = mk(14'h07A0, 8'hF1, 0, 0, 1, 8'h00, 0, 8'h0F, 1, 1, 1); // ADDWF 0x20,F
    tbl[2]  = mk(14'h0C21, 8'h02, 0, 0, 0, 8'h00, 0, 8'h81, 0, 1, 1); // RRF 0x21,W
    tbl[3]  = mk(14'h0BA2, 8'h01, 0, 0, 1, 8'h00, 1, 8'h81, 0, 1, 1); // DECFSZ -> 0
    tbl[4]  = mk(14'h0BA2, 8'h05, 0, 0, 1, 8'h04, 0, 8'h81, 0, 1, 1); // DECFSZ -> 4
    tbl[5]  = mk(14'h3000, 8'h00, 1, 1, 0, 8'h00, 0, 8'h81, 0, 1, 1); // illegal
    tbl[6]  = mk(14'h0000, 8'h00, 1, 0, 0, 8'h00, 0, 8'h81, 0, 1, 1); // NOP
    tbl[7]  = mk(14'h00B0, 8'h77, 0, 0, 1, 8'h81, 0, 8'h81, 0, 1, 1); // MOVWF 0x30
    tbl[8]  = mk(14'h0231, 8'h90, 0, 0, 0, 8'h00, 0, 8'h0F, 1, 0, 0); // SUBWF 0x31,W
    tbl[9]  = mk(14'h0100, 8'h55, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 1); // CLRW
    tbl[10] = mk(14'h0992, 8'h5A, 0, 0, 1, 8'hA5, 0, 8'h00, 1, 0, 0); // COMF 0x12,F
    tbl[11] = mk(14'h0D13, 8'h80, 0, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0); // RLF 0x13,W
    tbl[12] = mk(14'h0E94, 8'h3C, 0, 0, 1, 8'hC3, 0, 8'h01, 1, 0, 0); // SWAPF 0x14,F
    tbl[13] = mk(14'h2ABC, 8'h00, 1, 1, 0, 8'h00, 0, 8'h01, 1, 0, 0); // illegal

    for (int i = 0; i < 128; i++) fmem[i] = 8'(i);
    #12;
    chk("rst w_q", int'(w_q), 0);
    chk("rst status", int'({status_c, status_dc, status_z}), 0);
    chk("rst strobes", int'({done, skip, illegal, f_rd_en, f_wr_en}), 0);
    chk("rst controls", int'({clr, swap_n_mov, rlf_n_rrf, sub, op_mux_l, op_mux_a, out_mux}), 0);
    chk("rst operands", int'({op_a1, op_a, op_b}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst ready", int'(instr_ready), 1);

    prev_c = 1'b0;
    for (int i = 0; i < 14; i++) begin
      apply_chk($sformatf("vec%0d", i), tbl[i].ins, tbl[i].fv, tbl[i].sh, tbl[i].il, tbl[i].wr,
                tbl[i].wd, tbl[i].sk, tbl[i].w, tbl[i].c, tbl[i].dc, tbl[i].z, prev_c);
      prev_c = tbl[i].c;
    end

    mW = tbl[13].w; mC = tbl[13].c; mDC = tbl[13].dc; mZ = tbl[13].z;
    for (int i = 0; i < 150; i++) begin
      r_ins = 14'($urandom);
      if ($urandom_range(0, 9) != 0) r_ins[13:12] = 2'b00;
      r_fv = 8'($urandom);
      ref_exec(r_ins, r_fv, r_sh, r_il, r_wr, r_wd, r_sk, r_cin);
      apply_chk($sformatf("rnd%0d_%04h", i, r_ins), r_ins, r_fv, r_sh, r_il, r_wr, r_wd, r_sk,
                mW, mC, mDC, mZ, r_cin);
    end

    // Reset asserted during EX of ADDWF d=1 must suppress the write-back.
    fmem[7'h50] = 8'h33;
    @(negedge clk); instr_valid = 1'b1; instr = 14'h07D0;
    t = 0;
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    wrc = 0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (f_wr_en || done) wrc++; end
    chk("midrst no_write", wrc, 0);
    chk("midrst w_q", int'(w_q), 0);
    chk("midrst status", int'({status_c, status_dc, status_z}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst ready", int'(instr_ready), 1);
    mW = 8'h00; mC = 1'b0; mDC = 1'b0; mZ = 1'b0;

    // Back-to-back: valid held high; the next instr appears while busy and must not disturb the current one.
    fmem[7'h41] = 8'hFF;
    @(negedge clk); instr_valid = 1'b1; instr = 14'h00C0;
    t = 0;
    while (!instr_ready && t < 20) begin @(negedge clk); t++; end
    @(posedge clk);
    lows = 0; wk = -1; wa = 7'h00; wd = 8'hEE; rdy5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) instr = 14'h0AC1;
      if (k <= 4 && !instr_ready) lows++;
      if (f_wr_en) begin wk = k; wa = f_addr; wd = f_wr_data; end
      if (k == 5) rdy5 = instr_ready;
    end
    chk("b2b busy_cycles", lows, 4);
    chk("b2b ready_c5", int'(rdy5), 1);
    chk("b2b A wr_cycle", wk, 4);
    chk("b2b A wr_addr", int'(wa), 8'h40);
    chk("b2b A wr_data", int'(wd), 8'h00);
    @(posedge clk);
    wk = -1; rk = -1; wa = 7'h00; wd = 8'hEE;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) instr_valid = 1'b0;
      if (f_wr_en) begin wk = k; wa = f_addr; wd = f_wr_data; end
      if (instr_ready) begin rk = k; break; end
    end
    chk("b2b B wr_cycle", wk, 4);
    chk("b2b B wr_addr", int'(wa), 8'h41);
    chk("b2b B wr_data", int'(wd), 8'h00);
    chk("b2b B ready_cycle", rk, 5);
    chk("b2b B status", int'({status_c, status_dc, status_z}), 1);
    chk("b2b B w_q", int'(w_q), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
